// File: rtl/dram_cmd_scheduler.sv
// In-order request queue feeding a closed-page DDR command sequencer.
// Every request issues ACT, RD/WR, PRE separated by fixed controller-clock gaps.
module dram_cmd_scheduler #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned T_RCD         = 24,
    parameter int unsigned T_CL          = 24,
    parameter int unsigned T_CWL         = 20,
    parameter int unsigned T_BURST       = 4,
    parameter int unsigned T_RP          = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_ready_s,
    input  logic [1:0]               opcode,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic                     queue_full,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     cmd_valid,
    output logic [2:0]               cmd,
    output logic [1:0]               bank_group,
    output logic [1:0]               bank,
    output logic [13:0]              row,
    output logic [7:0]               col,
    output logic                     busy
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = 28;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_COUNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

    // Wait counter reload values: a gap of N clocks between issues spends N-1 cycles waiting.
    localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 2);
    localparam logic [7:0] RD_LOAD  = 8'(T_CL + T_BURST - 2);
    localparam logic [7:0] WR_LOAD  = 8'(T_CWL + T_BURST - 2);
    localparam logic [7:0] RP_LOAD  = 8'(T_RP - 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACT       = 3'd1;
    localparam logic [2:0] S_WAIT_RCD  = 3'd2;
    localparam logic [2:0] S_RW        = 3'd3;
    localparam logic [2:0] S_WAIT_DATA = 3'd4;
    localparam logic [2:0] S_PRE       = 3'd5;
    localparam logic [2:0] S_WAIT_RP   = 3'd6;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    // Entry layout: {opcode, address[31:6]}; the low six address bits carry no command field.
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head_entry;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [PTR_W:0]     count_d;
    logic               push, pop;
    logic               unused_addr;

    logic [2:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       is_write_q;
    logic [2:0] cmd_d;
    logic       busy_d;

    assign unused_addr = ^address[5:0];
    assign head_entry  = mem[head_q];
    assign push        = op_ready_s & ~queue_full;
    assign pop         = (state_d == S_PRE);

    always_comb begin
        count_d = queue_count;
        if (push && !pop) begin
            count_d = queue_count + ONE_COUNT;
        end else if (!push && pop) begin
            count_d = queue_count - ONE_COUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= {opcode, address[31:6]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            queue_count <= '0;
            queue_full  <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + ONE_PTR;
            if (pop)  head_q <= head_q + ONE_PTR;
            queue_count <= count_d;
            queue_full  <= (count_d == FULL_COUNT);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (queue_count != '0) state_d = S_ACT;
            end
            S_ACT: begin
                state_d = S_WAIT_RCD;
                wait_d  = RCD_LOAD;
            end
            S_WAIT_RCD: begin
                if (wait_q == 8'd0) state_d = S_RW;
                else                wait_d  = wait_q - 8'd1;
            end
            S_RW: begin
                state_d = S_WAIT_DATA;
                wait_d  = is_write_q ? WR_LOAD : RD_LOAD;
            end
            S_WAIT_DATA: begin
                if (wait_q == 8'd0) state_d = S_PRE;
                else                wait_d  = wait_q - 8'd1;
            end
            S_PRE: begin
                state_d = S_WAIT_RP;
                wait_d  = RP_LOAD;
            end
            S_WAIT_RP: begin
                if (wait_q == 8'd0) state_d = (queue_count != '0) ? S_ACT : S_IDLE;
                else                wait_d  = wait_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_d = CMD_NOP;
        case (state_d)
            S_ACT:   cmd_d = CMD_ACT;
            S_RW:    cmd_d = is_write_q ? CMD_WR : CMD_RD;
            S_PRE:   cmd_d = CMD_PRE;
            default: cmd_d = CMD_NOP;
        endcase
    end

    // busy stays up through the clock the FSM re-enters IDLE so the tRP window is covered.
    assign busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= 8'd0;
            is_write_q <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= CMD_NOP;
            busy       <= 1'b0;
            bank_group <= '0;
            bank       <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cmd_valid <= (cmd_d != CMD_NOP);
            cmd       <= cmd_d;
            busy      <= busy_d;
            if (state_d == S_ACT) begin
                is_write_q <= (head_entry[27:26] == 2'd1);
                bank_group <= head_entry[1:0];
                bank       <= head_entry[3:2];
                col        <= head_entry[11:4];
                row        <= head_entry[25:12];
            end else if (!busy_d) begin
                bank_group <= '0;
                bank       <= '0;
                row        <= '0;
                col        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench: request timing is predicted from the command rules with plain arithmetic,
// and a negedge monitor compares every issued command and the queue/busy status against it.
module tb_dram_cmd_scheduler;
    localparam int DEPTH   = 16;
    localparam int T_RCD   = 24;
    localparam int T_CL    = 24;
    localparam int T_CWL   = 20;
    localparam int T_BURST = 4;
    localparam int T_RP    = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_ready_s;
    logic [1:0]  opcode;
    logic [31:0] address;
    logic        queue_full;
    logic [4:0]  queue_count;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  bank_group;
    logic [1:0]  bank;
    logic [13:0] row;
    logic [7:0]  col;
    logic        busy;

    dram_cmd_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_ready_s (op_ready_s),
        .opcode     (opcode),
        .address    (address),
        .queue_full (queue_full),
        .queue_count(queue_count),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .bank_group (bank_group),
        .bank       (bank),
        .row        (row),
        .col        (col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct { longint e; int c; logic [25:0] f; } ev_t;
    typedef struct { longint push; longint act; longint pre; } req_t;

    ev_t    sb[$];
    req_t   acc[$];
    longint last_pre = -1000;
    longint edge_n = 0;
    longint last_drive_e = 0;
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    bit     busy_prev = 1'b0;
    longint act_log[$], actf_log[$], rw_log[$], rwc_log[$], pre_log[$], fall_log[$], cmd_log[$];

    longint mon_e;
    int     mon_c;
    bit     mon_b;
    ev_t    mon_ev;

    always @(posedge clk) edge_n++;

    task automatic chk(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    function automatic logic [25:0] fields_of(logic [31:0] a);
        return {a[7:6], a[9:8], a[31:18], a[17:10]};
    endfunction

    function automatic longint nth(longint q[$], int i);
        if (i < q.size()) return q[i];
        return -1000000;
    endfunction

    // Reference: request occupies the queue until its PRE edge; ACT waits for push+1 and tRP.
    task automatic model_push(longint e, logic [1:0] op, logic [31:0] a);
        int     occ = 0;
        longint act, rw, pre;
        foreach (acc[i]) if (acc[i].pre >= e) occ++;
        if (occ >= DEPTH) return;
        act = (e + 1 > last_pre + T_RP) ? e + 1 : last_pre + T_RP;
        rw  = act + T_RCD;
        pre = rw + ((op == 2'd1) ? T_CWL : T_CL) + T_BURST;
        last_pre = pre;
        acc.push_back('{e, act, pre});
        sb.push_back('{act, 1, fields_of(a)});
        sb.push_back('{rw, (op == 2'd1) ? 3 : 2, fields_of(a)});
        sb.push_back('{pre, 4, fields_of(a)});
    endtask

    task automatic drive(bit v, logic [1:0] op, logic [31:0] a);
        @(negedge clk);
        op_ready_s   = v;
        opcode       = op;
        address      = a;
        last_drive_e = edge_n;
        if (v) model_push(edge_n, op, a);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 2'd0, 32'd0);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending busy=%0d, required 0 pending busy=0",
                     sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic clear_logs();
        act_log.delete(); actf_log.delete(); rw_log.delete(); rwc_log.delete();
        pre_log.delete(); fall_log.delete(); cmd_log.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_e = edge_n - 1;
            mon_c = 0;
            mon_b = 1'b0;
            foreach (acc[i]) begin
                if (acc[i].push <= mon_e && acc[i].pre > mon_e) mon_c++;
                if (acc[i].act <= mon_e && mon_e <= acc[i].pre + T_RP) mon_b = 1'b1;
            end
            chk("queue_count", queue_count, mon_c);
            chk("queue_full", queue_full, mon_c == DEPTH);
            chk("busy", busy, mon_b);
            if (!mon_b) chk("idle_fields", {bank_group, bank, row, col}, 0);
            if (busy_prev && !busy) fall_log.push_back(mon_e);
            busy_prev = busy;
            if (cmd_valid) begin
                cmd_log.push_back(cmd);
                case (cmd)
                    3'd1: begin
                        act_log.push_back(mon_e);
                        actf_log.push_back({bank_group, bank, row, col});
                    end
                    3'd2, 3'd3: begin
                        rw_log.push_back(mon_e);
                        rwc_log.push_back(cmd);
                    end
                    3'd4: pre_log.push_back(mon_e);
                    default: ;
                endcase
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got cmd %0d at edge %0d, required none",
                             cmd, mon_e);
                end else begin
                    mon_ev = sb.pop_front();
                    chk("cmd_edge", mon_e, mon_ev.e);
                    chk("cmd_code", cmd, mon_ev.c);
                    chk("cmd_fields", {bank_group, bank, row, col}, mon_ev.f);
                end
            end else begin
                chk("nop_code", cmd, 0);
                if (sb.size() > 0 && sb[0].e < mon_e) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_cmd: got none by edge %0d, required cmd %0d at edge %0d",
                             mon_e, sb[0].c, sb[0].e);
                    sb.delete(0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint p;
        rst_n      = 1'b0;
        op_ready_s = 1'b0;
        opcode     = 2'd0;
        address    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_count", queue_count, 0);
        chk("reset_cmd", {cmd_valid, cmd}, 0);
        chk("reset_busy", busy, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Single read with known field decode and timing.
        clear_logs();
        drive(1'b1, 2'd0, 32'h0004_0A40);
        p = last_drive_e;
        idle(1);
        wait_drain(200);
        chk("t1_act", nth(act_log, 0) - p, 1);
        chk("t1_fields", nth(actf_log, 0), {2'd1, 2'd2, 14'd1, 8'd2});
        chk("t1_rd", nth(rw_log, 0) - p, 25);
        chk("t1_pre", nth(pre_log, 0) - p, 53);
        chk("t1_busy_fall", nth(fall_log, 0) - p, 78);

        // Single write.
        clear_logs();
        drive(1'b1, 2'd1, 32'h0004_0A40);
        p = last_drive_e;
        idle(1);
        wait_drain(200);
        chk("t2_act", nth(act_log, 0) - p, 1);
        chk("t2_wr", nth(rw_log, 0) - p, 25);
        chk("t2_wr_code", nth(rwc_log, 0), 3);
        chk("t2_pre", nth(pre_log, 0) - p, 49);

        // Fetch then read back to back.
        clear_logs();
        drive(1'b1, 2'd2, 32'h1234_5678);
        drive(1'b1, 2'd0, 32'h8765_4321);
        idle(1);
        wait_drain(400);
        chk("t3_gap", nth(act_log, 1) - nth(pre_log, 0), 24);
        chk("t3_fetch_is_rd", nth(rwc_log, 0), 2);

        // Fill the queue, overflow by one, then push on the first pop edge.
        clear_logs();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, (i == 0) ? 2'd0 : 2'($urandom_range(0, 2)), $urandom);
            if (i == 0) p = last_drive_e;
        end
        while (edge_n + 1 < p + 53) drive(1'b0, 2'd0, 32'd0);
        drive(1'b1, 2'd0, 32'hDEAD_BEEF);
        idle(1);
        chk("t4_count_after_pop", queue_count, 15);
        wait_drain(16 * 80 + 200);
        chk("t4_issued", act_log.size(), 16);

        // Random traffic that saturates the queue.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)), $urandom);
        end
        idle(1);
        wait_drain(16 * 80 + 200);

        // Reset during WAIT_DATA discards the in-flight request.
        drive(1'b1, 2'd0, 32'h0ABC_DE40);
        p = last_drive_e;
        idle(1);
        while (edge_n < p + 35) drive(1'b0, 2'd0, 32'd0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t6_rst_cmd", {cmd_valid, cmd}, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", {queue_full, queue_count}, 0);
        chk("t6_rst_fields", {bank_group, bank, row, col}, 0);
        sb.delete();
        acc.delete();
        last_pre  = -1000;
        busy_prev = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        clear_logs();
        drive(1'b1, 2'd1, 32'h5555_AAC0);
        idle(1);
        wait_drain(200);
        chk("t6_first_is_act", nth(cmd_log, 0), 1);
        chk("t6_cmd_total", cmd_log.size(), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
